// File: rtl/uart_defs.sv
// Shared UART definitions: receiver FSM state encodings and the bit-period
// derivation used by both the receiver and the transmitter.
package uart_defs;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Integer division: the bit period truncates toward zero.
  function automatic int clks_per_bit(input int clock_freq, input int bit_rate);
    return clock_freq / bit_rate;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with extra-MSB pointers.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage is not reset, so the head is masked while empty.
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling FSM, sticky error
// flags, and a FWFT byte FIFO toward the register block.
module uart_rx_buffered
  import uart_defs::*;
#(
  parameter int CLOCK_FREQ  = 25000000,
  parameter int BIT_RATE    = 115200,
  parameter int BUFFER_SIZE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd_en,
  input  logic       clear_errors,
  output logic [7:0] rd_data,
  output logic       rx_empty,
  output logic       rx_full,
  output logic       frame_error,
  output logic       overrun
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BIT_RATE);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic [1:0]    sync_ff;
  logic          rxs;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          bit_tick;
  logic          stop_sample;
  logic          push;
  logic          set_fe;
  logic          set_ov;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_ff <= 2'b11;
    else       sync_ff <= {sync_ff[0], rx};
  end

  assign rxs         = sync_ff[1];
  assign bit_tick    = (cnt == LAST_CNT);
  assign stop_sample = (state == ST_STOP) && bit_tick;
  assign push        = stop_sample && rxs;
  assign set_fe      = stop_sample && !rxs;
  // A pop on the stop-sample edge frees the slot, so only an unserviced full FIFO drops.
  assign set_ov      = push && rx_full && !rd_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!rxs) begin
            state <= ST_START;
            cnt   <= '0;
          end
        end
        ST_START: begin
          if (cnt == HALF_BIT) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rxs ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            cnt            <= '0;
            shift[bit_idx] <= rxs;
            bit_idx        <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP: begin
          // Leaving at mid-stop-bit lets a directly following start edge be caught.
          if (bit_tick) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else if (clear_errors) begin
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (set_fe) frame_error <= 1'b1;
      if (set_ov) overrun     <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(BUFFER_SIZE)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .pop    (rd_en),
    .wr_data(shift),
    .rd_data(rd_data),
    .empty  (rx_empty),
    .full   (rx_full)
  );

endmodule
